// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter: round-robin arbiter that shares one sram_bus read port among
// REQUESTERS clients. Flow: IDLE picks a winner, WAIT drives the bus read, DONE
// returns the data with a one-cycle grant.
// Optional feature macro: SRAM_READ_ARB_TIMEOUT_EN (aborts a read stuck in WAIT
// for TIMEOUT_CYCLES cycles and pulses timeout_strobe with the grant).
module sram_read_arbiter #(
    parameter int unsigned REQUESTERS        = 4,
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 15
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [REQUESTERS-1:0]                   req,
    input  logic [REQUESTERS*ADDRESS_BUS_WIDTH-1:0] req_addr,
    output logic [REQUESTERS-1:0]                   grant_strobe,
    output logic [DATA_BUS_WIDTH-1:0]               rd_data,
    output logic                                    bus_read_request,
    output logic [ADDRESS_BUS_WIDTH-1:0]            bus_read_address,
    input  logic                                    bus_read_finished,
    input  logic [DATA_BUS_WIDTH-1:0]               bus_read_data,
    output logic                                    busy,
    output logic                                    timeout_strobe
);

    localparam int unsigned AW = ADDRESS_BUS_WIDTH;
    localparam int unsigned IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(REQUESTERS - 1);
    localparam logic [REQUESTERS-1:0] GRANT_ONE = REQUESTERS'(1);

    // Reject parameter values the arbiter and its 5-bit wait counter cannot support.
    if (REQUESTERS < 1 || REQUESTERS > 16) begin : g_bad_requesters
        $error("sram_read_arbiter: REQUESTERS must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
        $error("sram_read_arbiter: TIMEOUT_CYCLES must be in 1..31");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [AW-1:0] pick_addr;

`ifdef SRAM_READ_ARB_TIMEOUT_EN
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);
    logic [4:0] wait_cnt;
    logic       timeout_hit;

    // Last permitted WAIT cycle: the wait counter started at zero on WAIT entry.
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`else
    // No abort path in this build.
    assign timeout_strobe = 1'b0;
`endif

    // First requester after the previous winner, wrapping modulo REQUESTERS.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= REQUESTERS; k++) begin
            cand = (32'(rr_ptr) + k) % REQUESTERS;
            if (!pick_valid && req[IW'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    // Address slice of the client currently picked.
    always_comb begin
        pick_addr = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (IW'(i) == pick_idx) begin
                pick_addr = req_addr[i*AW +: AW];
            end
        end
    end

    // Request is gated by finished so sram_bus never sees it in its own idle cycle.
    assign bus_read_request = (state == ST_WAIT) && !bus_read_finished;
    assign busy             = (state != ST_IDLE);

    // Arbiter state machine with registered grant, data and address outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            winner           <= '0;
            rr_ptr           <= LAST_IDX;
            grant_strobe     <= '0;
            rd_data          <= '0;
            bus_read_address <= '0;
`ifdef SRAM_READ_ARB_TIMEOUT_EN
            wait_cnt         <= '0;
            timeout_strobe   <= 1'b0;
`endif
        end else begin
            grant_strobe <= '0;
`ifdef SRAM_READ_ARB_TIMEOUT_EN
            timeout_strobe <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        winner           <= pick_idx;
                        bus_read_address <= pick_addr;
                        state            <= ST_WAIT;
`ifdef SRAM_READ_ARB_TIMEOUT_EN
                        wait_cnt         <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus_read_finished) begin
                        rd_data      <= bus_read_data;
                        grant_strobe <= GRANT_ONE << winner;
                        state        <= ST_DONE;
                    end
`ifdef SRAM_READ_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        rd_data        <= '0;
                        grant_strobe   <= GRANT_ONE << winner;
                        timeout_strobe <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
`endif
                end
                ST_DONE: begin
                    rr_ptr <= winner;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb_sram_read_arbiter: table-driven directed transactions, multi-cycle corner
// sequences, and a randomized phase checked against a timestamp-based model.
module tb_sram_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [AW-1:0]   addr [N];
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    grant_strobe;
    logic [DW-1:0]   rd_data;
    logic            bus_read_request;
    logic [AW-1:0]   bus_read_address;
    logic            bus_read_finished = 1'b0;
    logic [DW-1:0]   bus_read_data = '0;
    logic            busy;
    logic            timeout_strobe;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [N-1:0]  req;
        int            lat;
        logic [DW-1:0] data;
        logic [N-1:0]  grant;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

    sram_read_arbiter #(
        .REQUESTERS       (N),
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH   (DW),
        .TIMEOUT_CYCLES   (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_addr         (req_addr),
        .grant_strobe     (grant_strobe),
        .rd_data          (rd_data),
        .bus_read_request (bus_read_request),
        .bus_read_address (bus_read_address),
        .bus_read_finished(bus_read_finished),
        .bus_read_data    (bus_read_data),
        .busy             (busy),
        .timeout_strobe   (timeout_strobe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Round-robin choice: first requester after 'after', modulo N.
    function automatic int rr_pick(input logic [N-1:0] r, input int after);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (after + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Never more than one grant bit at once.
    always @(negedge clk) begin
        if (rst && grant_strobe != '0)
            chk("grant_onehot", 32'($onehot0(grant_strobe)), 32'd1);
    end

    // One full transaction starting in IDLE; bus finishes 'lat' cycles after the first WAIT cycle.
    task automatic serve(input string tag, input logic [N-1:0] r, input int lat,
                         input logic [DW-1:0] data, input logic [N-1:0] exp_g,
                         input logic [AW-1:0] exp_a);
        req = r;
        bus_read_finished = 1'b0;
        to_neg();
        chk({tag, "_idle_req"}, 32'(bus_read_request), 32'd0);
        to_pos();
        bus_read_finished = (lat == 0);
        bus_read_data = (lat == 0) ? data : DW'($urandom);
        to_neg();
        chk({tag, "_req_first"}, 32'(bus_read_request), 32'(lat != 0));
        chk({tag, "_addr"}, 32'(bus_read_address), 32'(exp_a));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int j = 1; j <= lat; j++) begin
            to_pos();
            bus_read_finished = (j == lat);
            bus_read_data = (j == lat) ? data : DW'($urandom);
            to_neg();
            chk({tag, "_req_wait"}, 32'(bus_read_request), 32'(j != lat));
            chk({tag, "_addr_hold"}, 32'(bus_read_address), 32'(exp_a));
            chk({tag, "_no_early_grant"}, 32'(grant_strobe), 32'd0);
        end
        to_pos();
        bus_read_finished = 1'b0;
        bus_read_data = DW'($urandom);
        to_neg();
        chk({tag, "_grant"}, 32'(grant_strobe), 32'(exp_g));
        chk({tag, "_rd_data"}, 32'(rd_data), 32'(data));
        chk({tag, "_req_done"}, 32'(bus_read_request), 32'd0);
        to_pos();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int next_sample, t_start, t_fin, t_grant, win, last, p, lat;
        logic [DW-1:0] fdata, exp_rd;
        logic [AW-1:0] faddr;

        addr[0] = 16'h1A00;
        addr[1] = 16'h2B11;
        addr[2] = 16'h4ABC;
        addr[3] = 16'h7F33;

        // rr pointer after the first grant is 0; expectations follow the rotation by hand.
        vecs[0] = '{req: 4'b0100, lat: 2, data: 16'h1234, grant: 4'b0100, addr: 16'h4ABC};
        vecs[1] = '{req: 4'b0101, lat: 1, data: 16'h0F0F, grant: 4'b0001, addr: 16'h1A00};
        vecs[2] = '{req: 4'b1111, lat: 3, data: 16'hA5A5, grant: 4'b0010, addr: 16'h2B11};
        vecs[3] = '{req: 4'b0010, lat: 1, data: 16'h8001, grant: 4'b0010, addr: 16'h2B11};
        vecs[4] = '{req: 4'b1001, lat: 2, data: 16'hFFFF, grant: 4'b1000, addr: 16'h7F33};
        vecs[5] = '{req: 4'b1001, lat: 1, data: 16'h0001, grant: 4'b0001, addr: 16'h1A00};
        vecs[6] = '{req: 4'b1000, lat: 0, data: 16'h3C3C, grant: 4'b1000, addr: 16'h7F33};

        // Reset held with all clients requesting.
        rst = 1'b0;
        req = 4'b1111;
        to_neg();
        to_neg();
        chk("rst_grant", 32'(grant_strobe), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_addr", 32'(bus_read_address), 32'd0);
        chk("rst_req", 32'(bus_read_request), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout_strobe), 32'd0);
        to_pos();
        rst = 1'b1;
        serve("t1", 4'b1111, 1, 16'hC0DE, 4'b0001, 16'h1A00);

        // Directed vector table.
        for (int v = 0; v < 7; v++)
            serve($sformatf("vec%0d", v), vecs[v].req, vecs[v].lat, vecs[v].data,
                  vecs[v].grant, vecs[v].addr);

        // No second read after a same-cycle finish; finished in IDLE is ignored.
        req = '0;
        bus_read_finished = 1'b1;
        bus_read_data = 16'hDEAD;
        to_neg();
        chk("idle_no_req", 32'(bus_read_request), 32'd0);
        chk("idle_no_busy", 32'(busy), 32'd0);
        to_pos();
        bus_read_finished = 1'b0;
        to_neg();
        chk("idle_no_grant", 32'(grant_strobe), 32'd0);
        chk("idle_rd_hold", 32'(rd_data), 32'h3C3C);
        chk("idle_still_idle", 32'(busy), 32'd0);
        to_pos();

        // Continuous requests rotate 0,1,2,3,... (rr pointer is 3 here).
        for (int k = 0; k < 8; k++)
            serve($sformatf("t3_%0d", k), 4'b1111, int'($urandom_range(3, 0)), DW'($urandom),
                  4'(1 << (k % 4)), addr[k % 4]);

        // Reset during client 3's WAIT while client 1 newly requests.
        req = 4'b1000;
        bus_read_finished = 1'b0;
        to_pos();
        to_neg();
        chk("t4_req_wait", 32'(bus_read_request), 32'd1);
        chk("t4_addr", 32'(bus_read_address), 32'h7F33);
        to_pos();
        req = 4'b1010;
        to_neg();
        chk("t4_req_hold", 32'(bus_read_request), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t4_req_drop", 32'(bus_read_request), 32'd0);
        chk("t4_busy_drop", 32'(busy), 32'd0);
        chk("t4_no_grant", 32'(grant_strobe), 32'd0);
        to_pos();
        bus_read_finished = 1'b1;
        bus_read_data = 16'hBAD0;
        to_neg();
        chk("t4_rst_grant", 32'(grant_strobe), 32'd0);
        chk("t4_rst_rd", 32'(rd_data), 32'd0);
        to_pos();
        bus_read_finished = 1'b0;
        rst = 1'b1;
        to_neg();
        chk("t4_post_idle", 32'(bus_read_request), 32'd0);
        to_pos();
        to_neg();
        chk("t4_c1_req", 32'(bus_read_request), 32'd1);
        chk("t4_c1_addr", 32'(bus_read_address), 32'h2B11);
        to_pos();
        bus_read_finished = 1'b1;
        bus_read_data = 16'h1111;
        to_neg();
        to_pos();
        bus_read_finished = 1'b0;
        to_neg();
        chk("t4_c1_grant", 32'(grant_strobe), 32'b0010);
        chk("t4_c1_rd", 32'(rd_data), 32'h1111);
        to_pos();
        req = '0;

        // Randomized phase against a timestamp model.
        rst = 1'b0;
        to_pos();
        to_pos();
        rst = 1'b1;
        last = N - 1;
        next_sample = 0;
        t_start = -100;
        t_fin = -100;
        t_grant = -100;
        win = 0;
        exp_rd = '0;
        fdata = '0;
        faddr = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (c - 1 == t_grant && win == i && $urandom_range(1, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    addr[i] = AW'($urandom);
                end
            end
            if (c == next_sample) begin
                p = rr_pick(req, last);
                if (p < 0) begin
                    next_sample = c + 1;
                end else begin
                    win = p;
                    last = p;
                    lat = int'($urandom_range(4, 0));
                    t_start = c + 1;
                    t_fin = c + 1 + lat;
                    t_grant = t_fin + 1;
                    next_sample = t_grant + 1;
                    fdata = DW'($urandom);
                    faddr = addr[p];
                end
            end
            if (c == t_fin) begin
                bus_read_finished = 1'b1;
                bus_read_data = fdata;
            end else if (c >= t_start && c < t_fin) begin
                bus_read_finished = 1'b0;
                bus_read_data = DW'($urandom);
            end else begin
                bus_read_finished = ($urandom_range(7, 0) == 0);
                bus_read_data = DW'($urandom);
            end
            to_neg();
            chk("rand_req", 32'(bus_read_request), 32'(c >= t_start && c < t_fin));
            chk("rand_busy", 32'(busy), 32'(c >= t_start && c <= t_grant));
            chk("rand_grant", 32'(grant_strobe), (c == t_grant) ? (32'd1 << win) : 32'd0);
            if (c == t_grant) exp_rd = fdata;
            chk("rand_rd_data", 32'(rd_data), 32'(exp_rd));
            if (c >= t_start && c <= t_fin)
                chk("rand_addr", 32'(bus_read_address), 32'(faddr));
`ifndef SRAM_READ_ARB_TIMEOUT_EN
            chk("rand_timeout_tied", 32'(timeout_strobe), 32'd0);
`endif
            to_pos();
        end

`ifdef SRAM_READ_ARB_TIMEOUT_EN
        // Bus never finishes: abort after 15 WAIT cycles with rd_data cleared.
        req = '0;
        bus_read_finished = 1'b0;
        rst = 1'b0;
        to_pos();
        to_pos();
        rst = 1'b1;
        serve("to_pre", 4'b0001, 1, 16'h5A5A, 4'b0001, addr[0]);
        req = 4'b0010;
        bus_read_finished = 1'b0;
        to_pos();
        for (int w = 1; w <= 15; w++) begin
            to_neg();
            chk($sformatf("to_wait_req%0d", w), 32'(bus_read_request), 32'd1);
            chk($sformatf("to_wait_flag%0d", w), 32'(timeout_strobe), 32'd0);
            chk($sformatf("to_wait_grant%0d", w), 32'(grant_strobe), 32'd0);
            to_pos();
        end
        to_neg();
        chk("to_strobe", 32'(timeout_strobe), 32'd1);
        chk("to_grant", 32'(grant_strobe), 32'b0010);
        chk("to_rd_zero", 32'(rd_data), 32'd0);
        chk("to_req_drop", 32'(bus_read_request), 32'd0);
        to_pos();
        req = '0;
        to_neg();
        chk("to_strobe_end", 32'(timeout_strobe), 32'd0);
        to_pos();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
